// File: rtl/dvp_dual_capture.sv
// dvp_dual_capture
//   Captures a dual-lane DVP stream (shared VSYNC/HREF, two 8-bit byte lanes)
//   and packs byte pairs into 16-bit pixels, one pixel per lane per strobe.
//   It also tags frame and line boundaries and checks the frame geometry.
//
// Ports
//   pclk, reset_n        pixel clock (rising edge), async active-low reset
//   enable               capture allowed while high
//   clr_err              one-cycle pulse, clears the sticky error flags
//   vsync, href, d1, d2  raw DVP inputs
//   pix_valid            one-cycle strobe qualifying pix_d1/pix_d2 and markers
//   pix_d1, pix_d2       {first byte, second byte} per lane
//   pix_sof/eol/eof      first pixel of frame / last pixel of line / of frame
//   frame_done           one-cycle pulse at frame close
//   frame_cnt            frames closed since enable rose (wraps)
//   last_lines           line count latched at frame close
//   err_line_len         sticky: a line was not H_BYTES long
//   err_line_cnt         sticky: a frame did not have V_LINES lines
module dvp_dual_capture #(
  parameter int H_BYTES = 2560,
  parameter int V_LINES = 720,
  parameter int LW      = 12
) (
  input  logic          pclk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          clr_err,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    d1,
  input  logic [7:0]    d2,
  output logic          pix_valid,
  output logic [15:0]   pix_d1,
  output logic [15:0]   pix_d2,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic          frame_done,
  output logic [7:0]    frame_cnt,
  output logic [LW-1:0] last_lines,
  output logic          err_line_len,
  output logic          err_line_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, SYNC, ACTIVE} state_t;

  state_t        state;
  logic          s_vsync, s_href, s_vsync_d, s_href_d, enable_d;
  logic [7:0]    s_d1, s_d2, hi_d1, hi_d2;
  logic          phase, sof_pend;
  logic [LW-1:0] bcnt, lcnt;
  logic          vld_p1, sof_p1, eol_p1, eof_p1;
  logic [15:0]   d1_p1, d2_p1;

  logic          vs_rise, vs_fall, href_fall, active, close, take;
  logic          in_range, pix_fire, last_pair, len_err, line_inc, cnt_err;
  logic [LW-1:0] lcnt_sat, lcnt_next;

  assign vs_rise   = s_vsync & ~s_vsync_d;
  assign vs_fall   = ~s_vsync & s_vsync_d;
  assign href_fall = ~s_href & s_href_d;
  assign active    = (state == ACTIVE);
  assign close     = active & vs_rise;
  // A byte arriving together with the closing VSYNC edge belongs to an aborted line.
  assign take      = active & s_href & ~vs_rise;
  assign in_range  = (bcnt < LW'(H_BYTES));
  assign pix_fire  = take & phase & in_range;
  assign last_pair = (bcnt == LW'(H_BYTES - 1));
  assign line_inc  = active & href_fall;
  assign len_err   = (take & ~in_range)
                   | (line_inc & (bcnt != LW'(H_BYTES)))
                   | (close & s_href);
  // Line counter saturates so a runaway frame cannot wrap back to a "good" count.
  assign lcnt_sat  = (lcnt == '1) ? lcnt : lcnt + LW'(1);
  assign lcnt_next = line_inc ? lcnt_sat : lcnt;
  assign cnt_err   = close & (lcnt_next != LW'(V_LINES));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      s_vsync      <= 1'b0;
      s_href       <= 1'b0;
      s_vsync_d    <= 1'b0;
      s_href_d     <= 1'b0;
      enable_d     <= 1'b0;
      state        <= IDLE;
      phase        <= 1'b0;
      sof_pend     <= 1'b0;
      bcnt         <= '0;
      lcnt         <= '0;
      vld_p1       <= 1'b0;
      sof_p1       <= 1'b0;
      eol_p1       <= 1'b0;
      eof_p1       <= 1'b0;
      pix_valid    <= 1'b0;
      pix_d1       <= '0;
      pix_d2       <= '0;
      pix_sof      <= 1'b0;
      pix_eol      <= 1'b0;
      pix_eof      <= 1'b0;
      frame_done   <= 1'b0;
      frame_cnt    <= '0;
      last_lines   <= '0;
      err_line_len <= 1'b0;
      err_line_cnt <= 1'b0;
    end else begin
      // stage p0: registered inputs and their delayed copies
      s_vsync   <= vsync;
      s_href    <= href;
      s_vsync_d <= s_vsync;
      s_href_d  <= s_href;
      enable_d  <= enable;

      case (state)
        IDLE:    if (enable) state <= ARM;
        ARM:     if (!enable) state <= IDLE;
                 else if (vs_rise) state <= SYNC;
        SYNC:    if (vs_fall) state <= enable ? ACTIVE : IDLE;
        ACTIVE:  if (vs_rise) state <= enable ? SYNC : IDLE;
        default: state <= IDLE;
      endcase

      if (state == SYNC && vs_fall && enable) sof_pend <= 1'b1;
      else if (pix_fire) sof_pend <= 1'b0;

      if (close || href_fall) begin
        phase <= 1'b0;
        bcnt  <= '0;
      end else if (take) begin
        phase <= ~phase;
        if (bcnt <= LW'(H_BYTES)) bcnt <= bcnt + LW'(1);
      end

      if (close) lcnt <= '0;
      else if (line_inc) lcnt <= lcnt_sat;

      frame_done <= close;
      if (close) begin
        last_lines <= lcnt_next;
        frame_cnt  <= frame_cnt + 8'd1;
      end
      if (enable && !enable_d) frame_cnt <= '0;

      // A new error in the same cycle as clr_err must stay visible.
      if (len_err) err_line_len <= 1'b1;
      else if (clr_err) err_line_len <= 1'b0;
      if (cnt_err) err_line_cnt <= 1'b1;
      else if (clr_err) err_line_cnt <= 1'b0;

      // stage p1: pixel formed on the second byte of a pair
      vld_p1 <= pix_fire;
      if (pix_fire) begin
        sof_p1 <= sof_pend;
        eol_p1 <= last_pair;
        eof_p1 <= last_pair & (lcnt == LW'(V_LINES - 1));
      end

      // stage p2: output register
      pix_valid <= vld_p1;
      pix_sof   <= vld_p1 & sof_p1;
      pix_eol   <= vld_p1 & eol_p1;
      pix_eof   <= vld_p1 & eof_p1;
      if (vld_p1) begin
        pix_d1 <= d1_p1;
        pix_d2 <= d2_p1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    // stage p0: registered byte lanes
    s_d1 <= d1;
    s_d2 <= d2;
    if (take && !phase) begin
      hi_d1 <= s_d1;
      hi_d2 <= s_d2;
    end
    // stage p1: packed pixel
    if (pix_fire) begin
      d1_p1 <= {hi_d1, s_d1};
      d2_p1 <= {hi_d2, s_d2};
    end
  end

endmodule

// File: tb/tb_dvp_dual_capture.sv
// tb_dvp_dual_capture
//   Drives DVP frames (fixed and random byte content, varied line lengths and
//   line counts) into dvp_dual_capture and compares every pixel, marker,
//   frame-close value and error flag against a frame-level model.
module tb_dvp_dual_capture;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int LW = 12;

  logic          pclk = 1'b0;
  logic          reset_n, enable, clr_err, vsync, href;
  logic [7:0]    d1, d2;
  logic          pix_valid, pix_sof, pix_eol, pix_eof, frame_done;
  logic [15:0]   pix_d1, pix_d2;
  logic [7:0]    frame_cnt;
  logic [LW-1:0] last_lines;
  logic          err_line_len, err_line_cnt;

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic        sof;
    logic        eol;
    logic        eof;
    logic [31:0] cyc;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        obs_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          fd_cnt   = 0;
  logic [31:0] cyc      = 0;

  // frame-level model state
  bit          cap;
  int          m_line;
  bit          m_first, m_err_len, m_err_cnt;
  int          m_last;
  logic [7:0]  m_fcnt;
  logic [7:0]  pat;

  dvp_dual_capture #(.H_BYTES(H), .V_LINES(V), .LW(LW)) dut (
    .pclk(pclk), .reset_n(reset_n), .enable(enable), .clr_err(clr_err),
    .vsync(vsync), .href(href), .d1(d1), .d2(d2),
    .pix_valid(pix_valid), .pix_d1(pix_d1), .pix_d2(pix_d2),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .last_lines(last_lines),
    .err_line_len(err_line_len), .err_line_cnt(err_line_cnt)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (pix_valid === 1'b1) obs_q.push_back({pix_d1, pix_d2, pix_sof, pix_eol, pix_eof, cyc});
    if (frame_done === 1'b1) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic vsync_pulse();
    @(negedge pclk); vsync = 1'b1;
    repeat (3) @(negedge pclk);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
  endtask

  task automatic model_close();
    if (cap) begin
      m_last = m_line;
      if (m_line != V) m_err_cnt = 1'b1;
      m_fcnt++;
    end
    m_line  = 0;
    m_first = 1'b1;
  endtask

  task automatic pulse_clr();
    @(negedge pclk); clr_err = 1'b1;
    @(negedge pclk); clr_err = 1'b0;
    m_err_len = 1'b0;
    m_err_cnt = 1'b0;
    @(negedge pclk);
  endtask

  // One HREF line of n bytes. Pixels pair bytes (0,1),(2,3)...; only pairs
  // inside the first H bytes are emitted; each appears 2 edges after its
  // second byte is sampled.
  task automatic send_line(input int n, input bit incr, input bit clr_hit, input bit abort);
    logic [7:0] h1, h2;
    pix_t p;
    h1 = '0;
    h2 = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      href = 1'b1;
      if (incr) begin d1 = pat; d2 = pat + 8'h70; pat++; end
      else begin d1 = 8'($urandom); d2 = 8'($urandom); end
      if (cap) begin
        if (i % 2 == 0) begin h1 = d1; h2 = d2; end
        else if (i < H) begin
          p.d1  = {h1, d1};
          p.d2  = {h2, d2};
          p.sof = m_first;
          p.eol = (i == H - 1);
          p.eof = (i == H - 1) && (m_line == V - 1);
          p.cyc = cyc + 3;
          exp_q.push_back(p);
          m_first = 1'b0;
        end
      end
    end
    if (abort) begin
      @(negedge pclk); vsync = 1'b1; d1 = 8'($urandom); d2 = 8'($urandom);
      @(negedge pclk); href = 1'b0;
      repeat (2) @(negedge pclk);
      vsync = 1'b0;
      if (cap) m_err_len = 1'b1;
      model_close();
      repeat (4) @(negedge pclk);
    end else begin
      @(negedge pclk); href = 1'b0;
      @(negedge pclk); if (clr_hit) clr_err = 1'b1;
      @(negedge pclk); clr_err = 1'b0;
      if (cap) begin
        if (clr_hit) begin m_err_len = 1'b0; m_err_cnt = 1'b0; end
        if (n != H) m_err_len = 1'b1;
        m_line++;
      end
      repeat (2) @(negedge pclk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge pclk);
    n_checks++;
    if ({pix_valid, pix_d1, pix_d2, pix_sof, pix_eol, pix_eof, frame_done, frame_cnt,
         last_lines, err_line_len, err_line_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b d1=%h d2=%h cnt=%h lines=%h errs=%b%b, required all zero",
               pix_valid, pix_d1, pix_d2, frame_cnt, last_lines, err_line_len, err_line_cnt);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge pclk);
    enable = 1'b1;
    repeat (3) @(negedge pclk);
  endtask

  task automatic test_clean_frame();
    int fd0;
    vsync_pulse();
    obs_q.delete(); exp_q.delete();
    cap = 1'b1; m_line = 0; m_first = 1'b1;
    fd0 = fd_cnt;
    pat = 8'h10;
    repeat (V) send_line(H, 1'b1, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL clean_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL clean_pix[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].d1 !== 16'h1011 || obs_q[0].d2 !== 16'h8081 || obs_q[0].sof !== 1'b1) begin
      n_fail++; $display("FAIL clean_first_pixel: got %h, required d1=1011 d2=8081 sof=1",
                         (obs_q.size() == 0) ? '0 : obs_q[0]);
    end
    n_checks++;
    if (fd_cnt - fd0 !== 1) begin
      n_fail++; $display("FAIL clean_frame_done: got %0d pulses, required 1", fd_cnt - fd0);
    end
    n_checks++;
    if (last_lines !== LW'(4) || frame_cnt !== 8'd1) begin
      n_fail++; $display("FAIL clean_close: got lines=%0d cnt=%0d, required lines=4 cnt=1", last_lines, frame_cnt);
    end
    n_checks++;
    if (err_line_len !== 1'b0 || err_line_cnt !== 1'b0) begin
      n_fail++; $display("FAIL clean_errors: got len=%b cnt=%b, required 0 0", err_line_len, err_line_cnt);
    end
  endtask

  task automatic test_short_line();
    obs_q.delete(); exp_q.delete();
    send_line(H, 1'b0, 1'b0, 1'b0);
    send_line(7, 1'b0, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0, 1'b0);
    send_line(H, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL short_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL short_pix[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({err_line_len, err_line_cnt, last_lines, frame_cnt} !== {m_err_len, m_err_cnt, LW'(m_last), m_fcnt}) begin
      n_fail++; $display("FAIL short_close: got len=%b cnt=%b lines=%0d fc=%0d, required len=%b cnt=%b lines=%0d fc=%0d",
                         err_line_len, err_line_cnt, last_lines, frame_cnt, m_err_len, m_err_cnt, m_last, m_fcnt);
    end
    pulse_clr();
    n_checks++;
    if (err_line_len !== 1'b0 || err_line_cnt !== 1'b0) begin
      n_fail++; $display("FAIL short_clr: got len=%b cnt=%b, required 0 0", err_line_len, err_line_cnt);
    end
  endtask

  task automatic test_long_frame();
    obs_q.delete(); exp_q.delete();
    repeat (V + 1) send_line(H, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL long_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL long_pix[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({err_line_len, err_line_cnt, last_lines, frame_cnt} !== {m_err_len, m_err_cnt, LW'(m_last), m_fcnt}) begin
      n_fail++; $display("FAIL long_close: got len=%b cnt=%b lines=%0d fc=%0d, required len=%b cnt=%b lines=%0d fc=%0d",
                         err_line_len, err_line_cnt, last_lines, frame_cnt, m_err_len, m_err_cnt, m_last, m_fcnt);
    end
    pulse_clr();
  endtask

  task automatic test_clr_collision();
    obs_q.delete(); exp_q.delete();
    send_line(7, 1'b0, 1'b0, 1'b0);
    send_line(7, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (err_line_len !== m_err_len) begin
      n_fail++; $display("FAIL clr_vs_set: got len=%b, required %b", err_line_len, m_err_len);
    end
    send_line(H, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (err_line_len !== m_err_len) begin
      n_fail++; $display("FAIL clr_clean_line: got len=%b, required %b", err_line_len, m_err_len);
    end
    send_line(H, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if ({err_line_cnt, last_lines, frame_cnt} !== {m_err_cnt, LW'(m_last), m_fcnt}) begin
      n_fail++; $display("FAIL clr_close: got cnt=%b lines=%0d fc=%0d, required cnt=%b lines=%0d fc=%0d",
                         err_line_cnt, last_lines, frame_cnt, m_err_cnt, m_last, m_fcnt);
    end
  endtask

  task automatic test_random_frames();
    int fd0, nl;
    for (int f = 0; f < 3; f++) begin
      obs_q.delete(); exp_q.delete();
      fd0 = fd_cnt;
      nl  = $urandom_range(V + 1, V - 1);
      for (int l = 0; l < nl; l++) send_line($urandom_range(H + 2, H - 2), 1'b0, 1'b0, 1'b0);
      vsync_pulse();
      model_close();
      n_checks++;
      if (obs_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL rand%0d_pix_count: got %0d, required %0d", f, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_pix[%0d]: got %h, required %h", f, i, obs_q[i], exp_q[i]);
        end
      end
      n_checks++;
      if ({fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt} !==
          {32'd1, m_err_len, m_err_cnt, LW'(m_last), m_fcnt}) begin
        n_fail++; $display("FAIL rand%0d_close: got fd=%0d len=%b cnt=%b lines=%0d fc=%0d, required fd=1 len=%b cnt=%b lines=%0d fc=%0d",
                           f, fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt,
                           m_err_len, m_err_cnt, m_last, m_fcnt);
      end
    end
    pulse_clr();
  endtask

  task automatic test_href_before_sync();
    int fd0;
    obs_q.delete(); exp_q.delete();
    fd0 = fd_cnt;
    enable = 1'b0;
    repeat (V) send_line(H, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if ({fd_cnt - fd0, frame_cnt} !== {32'd1, m_fcnt}) begin
      n_fail++; $display("FAIL disable_close: got fd=%0d fc=%0d, required fd=1 fc=%0d", fd_cnt - fd0, frame_cnt, m_fcnt);
    end
    cap = 1'b0;
    send_line(H, 1'b0, 1'b0, 1'b0);
    @(negedge pclk); enable = 1'b1; m_fcnt = '0;
    repeat (2) @(negedge pclk);
    n_checks++;
    if (frame_cnt !== m_fcnt) begin
      n_fail++; $display("FAIL enable_clears_cnt: got %0d, required %0d", frame_cnt, m_fcnt);
    end
    send_line(H, 1'b0, 1'b0, 1'b0);
    @(negedge pclk); vsync = 1'b1;
    repeat (2) @(negedge pclk);
    send_line(H, 1'b0, 1'b0, 1'b0);
    vsync = 1'b0;
    repeat (4) @(negedge pclk);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL presync_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    cap = 1'b1; m_line = 0; m_first = 1'b1;
  endtask

  task automatic test_abort();
    int fd0;
    obs_q.delete(); exp_q.delete();
    fd0 = fd_cnt;
    send_line(H, 1'b0, 1'b0, 1'b0);
    send_line(5, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL abort_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL abort_pix[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt} !==
        {32'd1, m_err_len, m_err_cnt, LW'(m_last), m_fcnt}) begin
      n_fail++; $display("FAIL abort_close: got fd=%0d len=%b cnt=%b lines=%0d fc=%0d, required fd=1 len=%b cnt=%b lines=%0d fc=%0d",
                         fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt,
                         m_err_len, m_err_cnt, m_last, m_fcnt);
    end
  endtask

  task automatic test_reset_mid();
    int fd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk); href = 1'b1; d1 = 8'($urandom); d2 = 8'($urandom);
    end
    @(negedge pclk); reset_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_valid, pix_d1, pix_d2, pix_sof, pix_eol, pix_eof, frame_done, frame_cnt,
         last_lines, err_line_len, err_line_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got valid=%b d1=%h cnt=%0d lines=%0d errs=%b%b, required all zero",
               pix_valid, pix_d1, frame_cnt, last_lines, err_line_len, err_line_cnt);
    end
    m_fcnt = '0; m_err_len = 1'b0; m_err_cnt = 1'b0; m_last = 0; cap = 1'b0;
    obs_q.delete(); exp_q.delete();
    repeat (3) @(negedge pclk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge pclk); d1 = 8'($urandom); d2 = 8'($urandom);
    end
    @(negedge pclk); href = 1'b0;
    repeat (4) @(negedge pclk);
    n_checks++;
    if (obs_q.size() !== 0) begin
      n_fail++; $display("FAIL reset_no_partial: got %0d pixels, required 0", obs_q.size());
    end
    vsync_pulse();
    cap = 1'b1; m_line = 0; m_first = 1'b1;
    fd0 = fd_cnt;
    repeat (V) send_line(H, 1'b0, 1'b0, 1'b0);
    vsync_pulse();
    model_close();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL reset_pix_count: got %0d, required %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL reset_pix[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt} !==
        {32'd1, 1'b0, 1'b0, LW'(V), 8'd1}) begin
      n_fail++; $display("FAIL reset_restart: got fd=%0d len=%b cnt=%b lines=%0d fc=%0d, required fd=1 len=0 cnt=0 lines=%0d fc=1",
                         fd_cnt - fd0, err_line_len, err_line_cnt, last_lines, frame_cnt, V);
    end
  endtask

  initial begin
    reset_n = 1'b1; enable = 1'b0; clr_err = 1'b0;
    vsync = 1'b0; href = 1'b0; d1 = '0; d2 = '0;
    cap = 1'b0; m_line = 0; m_first = 1'b1; m_err_len = 1'b0; m_err_cnt = 1'b0;
    m_last = 0; m_fcnt = '0; pat = '0;
    #2 reset_n = 1'b0;
    test_reset();
    test_clean_frame();
    test_short_line();
    test_long_frame();
    test_clr_collision();
    test_random_frames();
    test_href_before_sync();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
